// File: rtl/segment_prob_scheduler_pkg.sv
// Shared constants for the segment randomisation sequencer: state encoding,
// probability thresholds per class and LFSR tap positions.
`ifndef RNDSIZE
`define RNDSIZE 16
`endif
`ifndef BITMAP_NB_SEGMENTS
`define BITMAP_NB_SEGMENTS 7
`endif

package segment_prob_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // Segment is ON when the 4-bit LFSR sample is below the class threshold.
  localparam logic [3:0] THR_C0 = 4'd8;
  localparam logic [3:0] THR_C1 = 4'd10;
  localparam logic [3:0] THR_C2 = 4'd12;
  localparam logic [3:0] THR_C3 = 4'd14;

  // Low taps; the top tap is always RNDSIZE-1.
  localparam int TAP_A = 3;
  localparam int TAP_B = 2;
  localparam int TAP_C = 0;

  function automatic logic [3:0] class_thr(input logic [1:0] cls);
    case (cls)
      2'b00:   class_thr = THR_C0;
      2'b01:   class_thr = THR_C1;
      2'b10:   class_thr = THR_C2;
      default: class_thr = THR_C3;
    endcase
  endfunction

endpackage

// File: rtl/segment_prob_scheduler_lfsr_step.sv
// Combinational LFSR next-state plus 4-bit threshold decision; shared with
// the datapath expander so both sides use the same polynomial.
module seg_lfsr_step
  import segment_prob_scheduler_pkg::*;
#(
  parameter int RNDSIZE = `RNDSIZE
) (
  input  logic [RNDSIZE-1:0] lfsr,
  input  logic [1:0]         cls,
  output logic [RNDSIZE-1:0] lfsr_next,
  output logic               seg_on
);

  logic fb;

  assign fb        = lfsr[RNDSIZE-1] ^ lfsr[TAP_A] ^ lfsr[TAP_B] ^ lfsr[TAP_C];
  assign lfsr_next = {lfsr[RNDSIZE-2:0], fb};
  assign seg_on    = (lfsr[3:0] < class_thr(cls));

endmodule

// File: rtl/segment_prob_scheduler.sv
// Frame sequencer: steps the LFSR once per segment, builds one bitmap per
// digit and hands it downstream on valid/ready. Optional SEGPROB_ALWAYS_ON_EN
// adds a per-digit always_on override.
//
// state | meaning
// IDLE  | waiting for start / seed_load
// GEN   | one segment decided per cycle for the current digit
// OUT   | bitmap presented, waiting for out_ready
module segment_prob_scheduler
  import segment_prob_scheduler_pkg::*;
#(
  parameter int RNDSIZE     = `RNDSIZE,
  parameter int NB_SEGMENTS = `BITMAP_NB_SEGMENTS,
  parameter int NB_DIGITS   = 2,
  parameter int RESET_SEED  = 1,
  localparam int DIG_W = (NB_DIGITS > 1) ? $clog2(NB_DIGITS) : 1,
  localparam int SEG_W = (NB_SEGMENTS > 1) ? $clog2(NB_SEGMENTS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [2*NB_DIGITS-1:0] prob_cfg,
`ifdef SEGPROB_ALWAYS_ON_EN
  input  logic [NB_DIGITS-1:0]   always_on,
`endif
  input  logic                   seed_load,
  input  logic [RNDSIZE-1:0]     seed,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NB_SEGMENTS-1:0] out_bitmap,
  output logic [DIG_W-1:0]       out_digit,
  output logic                   busy,
  output logic                   done
);

  state_t                   state_q, state_d;
  logic [RNDSIZE-1:0]       lfsr_q, lfsr_next;
  logic [2*NB_DIGITS-1:0]   prob_q;
  logic [DIG_W-1:0]         digit_q;
  logic [SEG_W-1:0]         seg_q;
  logic [NB_SEGMENTS-1:0]   bitmap_q;
  logic                     done_q;
  logic [1:0]               cls;
  logic                     seg_on, seg_force;
  logic                     last_seg, last_digit;

`ifdef SEGPROB_ALWAYS_ON_EN
  logic [NB_DIGITS-1:0]     aon_q;
`endif

  assign last_seg   = (seg_q == SEG_W'(NB_SEGMENTS - 1));
  assign last_digit = (digit_q == DIG_W'(NB_DIGITS - 1));

  always_comb begin
    cls       = 2'b00;
    seg_force = 1'b0;
    for (int d = 0; d < NB_DIGITS; d++) begin
      if (digit_q == DIG_W'(d)) begin
        cls = prob_q[2*d +: 2];
`ifdef SEGPROB_ALWAYS_ON_EN
        seg_force = aon_q[d];
`endif
      end
    end
  end

  seg_lfsr_step #(.RNDSIZE(RNDSIZE)) u_step (
    .lfsr      (lfsr_q),
    .cls       (cls),
    .lfsr_next (lfsr_next),
    .seg_on    (seg_on)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!seed_load && start) state_d = ST_GEN;
      ST_GEN:  if (last_seg) state_d = ST_OUT;
      ST_OUT:  if (out_ready) state_d = last_digit ? ST_IDLE : ST_GEN;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid  = (state_q == ST_OUT);
    busy       = (state_q != ST_IDLE);
    done       = done_q;
    out_bitmap = bitmap_q;
    out_digit  = digit_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q   <= RNDSIZE'(RESET_SEED);
      prob_q   <= '0;
      digit_q  <= '0;
      seg_q    <= '0;
      bitmap_q <= '0;
      done_q   <= 1'b0;
`ifdef SEGPROB_ALWAYS_ON_EN
      aon_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (seed_load) begin
            // An all-zero LFSR would lock up, so zero seeds load as 1.
            lfsr_q <= (seed == '0) ? RNDSIZE'(1) : seed;
          end else if (start) begin
            prob_q  <= prob_cfg;
            digit_q <= '0;
            seg_q   <= '0;
`ifdef SEGPROB_ALWAYS_ON_EN
            aon_q   <= always_on;
`endif
          end
        end
        ST_GEN: begin
          bitmap_q[seg_q] <= seg_on | seg_force;
          lfsr_q          <= lfsr_next;
          seg_q           <= seg_q + SEG_W'(1);
        end
        ST_OUT: begin
          if (out_ready) begin
            if (last_digit) begin
              done_q <= 1'b1;
            end else begin
              digit_q <= digit_q + DIG_W'(1);
              seg_q   <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
